// File: rtl/common_types_pkg.sv
// Shared types for the core memory subsystem.
package common_types_pkg;

  typedef logic [31:0] word_t;

  // Access sequencing on the shared RAM port.
  typedef enum logic [1:0] {
    RAM_IDLE,
    RAM_WAIT,
    RAM_DONE
  } ram_state_t;

  // Which requester currently owns the RAM port.
  typedef enum logic {
    OWNER_I,
    OWNER_D
  } mem_owner_t;

endpackage

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access.
// Data has priority; a starve counter forces a fetch grant after
// STARVE_LIMIT consecutive data grants while fetch is waiting.
module memory_arbiter
  import common_types_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  input  logic        d_ren,
  input  logic        d_wen,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_strobe,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        ram_ren,
  output logic        ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_strobe,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ready
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);

  ram_state_t      state_q, state_d;
  mem_owner_t      owner_q, owner_d;
  word_t           addr_q, addr_d;
  word_t           wdata_q, wdata_d;
  logic [3:0]      strobe_q, strobe_d;
  logic            is_write_q, is_write_d;
  word_t           rdata_q, rdata_d;
  logic [CntW-1:0] starve_q, starve_d;

  logic d_req;
  logic fetch_wins;

  assign d_req      = d_ren | d_wen;
  assign fetch_wins = i_req & (~d_req | (starve_q == StarveMax));

  // Next-state: arbitration in IDLE, wait for RAM completion, one-cycle DONE.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    strobe_d   = strobe_q;
    is_write_d = is_write_q;
    rdata_d    = rdata_q;
    starve_d   = starve_q;
    unique case (state_q)
      RAM_IDLE: begin
        if (i_req || d_req) begin
          state_d = RAM_WAIT;
          rdata_d = '0;
          if (fetch_wins) begin
            owner_d    = OWNER_I;
            addr_d     = i_addr;
            wdata_d    = '0;
            strobe_d   = 4'b1111;
            is_write_d = 1'b0;
            starve_d   = '0;
          end else begin
            owner_d    = OWNER_D;
            addr_d     = d_addr;
            wdata_d    = d_wdata;
            // Write wins when both enables are set.
            is_write_d = d_wen;
            strobe_d   = d_wen ? d_strobe : 4'b1111;
            if (!i_req) begin
              starve_d = '0;
            end else if (starve_q != StarveMax) begin
              starve_d = starve_q + CntW'(1);
            end
          end
        end
      end
      RAM_WAIT: begin
        if (ram_ready) begin
          state_d = RAM_DONE;
          if (!is_write_q) begin
            rdata_d = ram_rdata;
          end
        end
      end
      RAM_DONE: state_d = RAM_IDLE;
      default:  state_d = RAM_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q    <= RAM_IDLE;
      owner_q    <= OWNER_I;
      addr_q     <= '0;
      wdata_q    <= '0;
      strobe_q   <= '0;
      is_write_q <= 1'b0;
      rdata_q    <= '0;
      starve_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      strobe_q   <= strobe_d;
      is_write_q <= is_write_d;
      rdata_q    <= rdata_d;
      starve_q   <= starve_d;
    end
  end

  // Outputs decoded from registered state only; zero outside their active state.
  always_comb begin
    ram_ren    = 1'b0;
    ram_wen    = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    ram_strobe = '0;
    i_ready    = 1'b0;
    d_ready    = 1'b0;
    i_rdata    = '0;
    d_rdata    = '0;
    if (state_q == RAM_WAIT) begin
      ram_ren    = ~is_write_q;
      ram_wen    = is_write_q;
      ram_addr   = addr_q;
      ram_wdata  = wdata_q;
      ram_strobe = strobe_q;
    end
    if (state_q == RAM_DONE) begin
      if (owner_q == OWNER_I) begin
        i_ready = 1'b1;
        i_rdata = rdata_q;
      end else begin
        d_ready = 1'b1;
        d_rdata = rdata_q;
      end
    end
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Single-port memory arbiter between the instruction-fetch path and the data-access path of the core. It grants one requester at a time to the shared RAM port and sequences each access through RAM_IDLE → RAM_WAIT → RAM_DONE. Data accesses have priority; a bounded-starvation counter guarantees forward progress for fetch. It sits between the fetch/memory pipeline stages and the RAM model or bus interface.

## Interface
Parameters:
- STARVE_LIMIT, 4: max consecutive data grants while fetch is waiting; fetch then wins the next arbitration.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- nrst  in  1  reset, synchronous, active-low.
- i_req  in  1  fetch read request; held until i_ready.
- i_addr  in  32  fetch word address.
- i_rdata  out  32  fetch read data; valid while i_ready.
- i_ready  out  1  one-cycle completion pulse to fetch.
- d_ren  in  1  data read request; held until d_ready.
- d_wen  in  1  data write request; held until d_ready.
- d_addr  in  32  data address.
- d_wdata  in  32  data write data.
- d_strobe  in  4  byte-lane write enables.
- d_rdata  out  32  data read data; valid while d_ready.
- d_ready  out  1  one-cycle completion pulse to data path.
- ram_ren  out  1  RAM read enable.
- ram_wen  out  1  RAM write enable.
- ram_addr  out  32  RAM address.
- ram_wdata  out  32  RAM write data.
- ram_strobe  out  4  RAM byte enables; 4'b1111 for reads.
- ram_rdata  in  32  RAM read data; sampled on ram_ready.
- ram_ready  in  1  RAM completion, one-cycle pulse.

## Operation
- State register of type ram_state_t; owner register of type mem_owner_t; latched request registers (addr, wdata, strobe, is_write); 32-bit read-data register; starve counter, width $clog2(STARVE_LIMIT+1).
- RAM_IDLE: all RAM enables low. If any request: choose winner, latch its request fields and owner, go RAM_WAIT. Otherwise stay.
- Winner: fetch if i_req and (no data request or starve_cnt == STARVE_LIMIT); else data.
- Starve counter: on data grant with i_req high, increment (saturating at STARVE_LIMIT); on data grant with i_req low, clear; on fetch grant, clear.
- d_wen and d_ren both high: treated as write.
- RAM_WAIT: drive ram_ren/ram_wen/ram_addr/ram_wdata/ram_strobe from latched registers. On ram_ready: capture ram_rdata (reads only), go RAM_DONE. Otherwise hold.
- RAM_DONE: RAM enables low; assert owner's ready for exactly this cycle, drive the captured data on that owner's rdata; go RAM_IDLE unconditionally.
- ram_ready outside RAM_WAIT is ignored.
- A requester dropping its request during RAM_WAIT does not abort: the access completes and ready still pulses.
- No alignment checking; the address passes through unmodified.

## Timing
- Reset (nrst low at edge): state RAM_IDLE, starve_cnt 0, latched registers 0; all outputs 0. Reset during RAM_WAIT abandons the access; no ready pulse follows.
- Request sampled in IDLE at edge N → RAM enables high in cycle N+1. With ram_ready in cycle N+1 → DONE and ready high in cycle N+2. Minimum latency 2 cycles; general latency = 2 + RAM wait cycles.
- The RAM_DONE → RAM_IDLE cycle guarantees that a requester deasserting on the edge after ready is never re-granted. Back-to-back accesses have 3-cycle minimum spacing.
- rdata outputs are 0 whenever the corresponding ready is low.
- Only one of i_ready/d_ready is ever high; ram_ren and ram_wen are never both high.

## Structure
- Add to common_types_pkg: typedef enum logic {OWNER_I, OWNER_D} mem_owner_t. Reuse ram_state_t and word_t.
- Single module, no sub-modules. The grant logic is combinational inside it; all state is registered.

## Test plan
- Fetch read only: i_req=1, i_addr=0x100, RAM ready 1 cycle later with 0xDEADBEEF → ram_ren in cycle 1, i_ready and i_rdata=0xDEADBEEF in cycle 2 only.
- Simultaneous i_req and d_wen (addr 0x200, wdata 0x12345678, strobe 4'b0011) → data granted first; ram_wen=1, ram_strobe=0011; fetch completes after d_ready.
- Starvation: i_req held, data requests re-issued continuously, STARVE_LIMIT=4 → exactly 4 data grants, then fetch granted; counter returns to 0.
- RAM wait of 5 cycles on a data read → enables held steady for 5 cycles, d_ready in the cycle after ram_ready; spurious ram_ready in IDLE ignored.
- nrst low during RAM_WAIT → next cycle all outputs 0, state IDLE, no ready pulse; a new request afterwards completes normally.
- d_ren and d_wen both high → write issued (ram_wen=1, ram_ren=0).
